// File: rtl/id_ex_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_stage_if
//
// Purpose
//   Bundles the decode-side inputs and the EX-side outputs of the ID/EX
//   pipeline register. This leaves the stage module with only clk and rst as
//   scalar ports.
//
// Parameters
//   DW  datapath width of register operands, immediate and PC
//   RW  register-select width
//
// Signals
//   id_valid                      decode stage holds a real instruction
//   id_read1data / id_read2data   operands from the bypassing register file
//   id_read1sel  / id_read2sel    source registers of the decode instruction
//   id_uses_rs   / id_uses_rt     instruction really consumes read1 / read2
//   id_wrsel                      destination register
//   id_regwrite / id_memread      writes a register / is a load
//   id_imm / id_pc                immediate and PC+2
//   id_err                        register-file error for this instruction
//   flush                         branch/jump redirect, kills decode instr
//   ex_hold                       downstream cannot accept, freeze EX
//   ex_*                          registered EX-stage control and data
//   stall_id                      combinational hold request to IF/ID
//   stall_cnt                     saturating count of load-use bubbles
//
// Modports
//   master  the decode/pipeline-control side, which drives id_*, flush and
//           ex_hold
//   slave   the id_ex_stage itself
// -----------------------------------------------------------------------------
interface id_ex_stage_if #(
    parameter int DW = 16,
    parameter int RW = 3
);
    // Decode-side fields
    logic          id_valid;
    logic [DW-1:0] id_read1data;
    logic [DW-1:0] id_read2data;
    logic [RW-1:0] id_read1sel;
    logic [RW-1:0] id_read2sel;
    logic          id_uses_rs;
    logic          id_uses_rt;
    logic [RW-1:0] id_wrsel;
    logic          id_regwrite;
    logic          id_memread;
    logic [DW-1:0] id_imm;
    logic [DW-1:0] id_pc;
    logic          id_err;

    // Pipeline control
    logic          flush;
    logic          ex_hold;

    // EX-side registered fields
    logic          ex_valid;
    logic          ex_regwrite;
    logic          ex_memread;
    logic          ex_err;
    logic [DW-1:0] ex_read1data;
    logic [DW-1:0] ex_read2data;
    logic [DW-1:0] ex_imm;
    logic [DW-1:0] ex_pc;
    logic [RW-1:0] ex_wrsel;

    // Hazard reporting
    logic          stall_id;
    logic [7:0]    stall_cnt;

    modport master (
        output id_valid, id_read1data, id_read2data, id_read1sel, id_read2sel,
               id_uses_rs, id_uses_rt, id_wrsel, id_regwrite, id_memread,
               id_imm, id_pc, id_err, flush, ex_hold,
        input  ex_valid, ex_regwrite, ex_memread, ex_err, ex_read1data,
               ex_read2data, ex_imm, ex_pc, ex_wrsel, stall_id, stall_cnt
    );

    modport slave (
        input  id_valid, id_read1data, id_read2data, id_read1sel, id_read2sel,
               id_uses_rs, id_uses_rt, id_wrsel, id_regwrite, id_memread,
               id_imm, id_pc, id_err, flush, ex_hold,
        output ex_valid, ex_regwrite, ex_memread, ex_err, ex_read1data,
               ex_read2data, ex_imm, ex_pc, ex_wrsel, stall_id, stall_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// Purpose
//   ID/EX pipeline register with load-use hazard detection.
//   - A load sitting in EX whose destination feeds an operand of the
//     instruction in decode forces one bubble into EX. In the same cycle it
//     asks IF/ID to hold the instruction.
//   - flush kills the decode instruction. It always wins, even over ex_hold.
//   - ex_hold freezes the whole EX register and the bubble counter.
//   - stall_cnt counts inserted load-use bubbles and saturates at 255.
//
// Ports
//   clk  single clock, rising edge
//   rst  asynchronous, active-high reset; clears EX register and stall_cnt
//   bus  id_ex_stage_if.slave (decode inputs, control, EX outputs)
//
// Per-edge priority: rst > flush > ex_hold > load-use > normal capture.
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic         clk,
    input  logic         rst,
    id_ex_stage_if.slave bus
);

    // Everything the EX register holds. The all-zero value is a bubble.
    typedef struct packed {
        logic          valid;
        logic          regwrite;
        logic          memread;
        logic          err;
        logic [DW-1:0] read1data;
        logic [DW-1:0] read2data;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc;
        logic [RW-1:0] wrsel;
    } ex_reg_t;

    // The one update the EX register performs on this edge, in priority order.
    typedef enum logic [1:0] {
        ACT_FLUSH,    // redirect: load a bubble
        ACT_HOLD,     // downstream busy: keep everything
        ACT_BUBBLE,   // load-use: load a bubble and count it
        ACT_CAPTURE   // normal: take the decode instruction
    } ex_action_t;

    localparam logic [7:0] CNT_MAX = 8'hFF;

    ex_reg_t    ex_q;
    ex_reg_t    ex_d;
    ex_reg_t    id_fields;
    ex_action_t action;
    logic [7:0] stall_cnt_q;
    logic       src1_hit;
    logic       src2_hit;
    logic       load_use;

    // ---------------------------------------------------------------------
    // Hazard detection
    // ---------------------------------------------------------------------
    // Full-width select compare. Register 0 is an ordinary register here,
    // so a load to r0 followed by a read of r0 still stalls.
    assign src1_hit = bus.id_uses_rs && (bus.id_read1sel == ex_q.wrsel);
    assign src2_hit = bus.id_uses_rt && (bus.id_read2sel == ex_q.wrsel);

    assign load_use = ex_q.valid && ex_q.memread && ex_q.regwrite &&
                      bus.id_valid && (src1_hit || src2_hit);

    // IF/ID holds whenever EX will not take the decode instruction, unless
    // that instruction is being flushed anyway.
    assign bus.stall_id = !bus.flush && (bus.ex_hold || load_use);

    // ---------------------------------------------------------------------
    // Next-state selection
    // ---------------------------------------------------------------------
    // The decode instruction as EX would capture it. Side-effecting control
    // bits are forced low for an invalid slot, so garbage on the decode bus
    // cannot write a register or start a load later.
    always_comb begin
        id_fields           = '0;
        id_fields.valid     = bus.id_valid;
        id_fields.regwrite  = bus.id_valid && bus.id_regwrite;
        id_fields.memread   = bus.id_valid && bus.id_memread;
        id_fields.err       = bus.id_valid && bus.id_err;
        id_fields.read1data = bus.id_read1data;
        id_fields.read2data = bus.id_read2data;
        id_fields.imm       = bus.id_imm;
        id_fields.pc        = bus.id_pc;
        id_fields.wrsel     = bus.id_wrsel;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first. A path that
        // leaves it unassigned would make synthesis infer a latch.
        action = ACT_CAPTURE;
        if (bus.flush) begin
            action = ACT_FLUSH;
        end else if (bus.ex_hold) begin
            action = ACT_HOLD;
        end else if (load_use) begin
            action = ACT_BUBBLE;
        end
    end

    always_comb begin
        ex_d = ex_q;
        case (action)
            ACT_FLUSH:   ex_d = '0;
            ACT_HOLD:    ex_d = ex_q;
            ACT_BUBBLE:  ex_d = '0;
            ACT_CAPTURE: ex_d = id_fields;
            default:     ex_d = '0;
        endcase
    end

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    // NOTE: the reset is asynchronous, so the outputs go to zero as soon as
    // rst rises, without waiting for clk. It also discards any instruction
    // that was being held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments only.
            // This way every register samples pre-edge values.
            ex_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q <= ex_d;
            if (action == ACT_BUBBLE && stall_cnt_q != CNT_MAX) begin
                stall_cnt_q <= stall_cnt_q + 8'd1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign bus.ex_valid     = ex_q.valid;
    assign bus.ex_regwrite  = ex_q.regwrite;
    assign bus.ex_memread   = ex_q.memread;
    assign bus.ex_err       = ex_q.err;
    assign bus.ex_read1data = ex_q.read1data;
    assign bus.ex_read2data = ex_q.read2data;
    assign bus.ex_imm       = ex_q.imm;
    assign bus.ex_pc        = ex_q.pc;
    assign bus.ex_wrsel     = ex_q.wrsel;
    assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Self-checking bench for id_ex_stage. A behavioural model of the EX
// register and bubble counter is kept here. It is stepped once per rising
// edge from the same inputs the DUT sees. Inputs change at posedge+1.
// stall_id is checked just before each edge. The registered outputs are
// checked at posedge+1.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int DW = 16;
    localparam int RW = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    id_ex_stage_if #(.DW(DW), .RW(RW)) bus ();

    id_ex_stage #(.DW(DW), .RW(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model of what EX should hold
    logic          m_valid, m_regwrite, m_memread, m_err;
    logic [DW-1:0] m_r1, m_r2, m_imm, m_pc;
    logic [RW-1:0] m_wrsel;
    int            m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_valid = 0; m_regwrite = 0; m_memread = 0; m_err = 0;
        m_r1 = '0; m_r2 = '0; m_imm = '0; m_pc = '0; m_wrsel = '0;
        m_cnt = 0;
    endtask

    task automatic model_bubble();
        m_valid = 0; m_regwrite = 0; m_memread = 0; m_err = 0;
        m_r1 = '0; m_r2 = '0; m_imm = '0; m_pc = '0; m_wrsel = '0;
    endtask

    // A load in EX whose destination is a source the decode instruction uses
    function automatic bit model_lu();
        bit dep;
        dep = (bus.id_uses_rs && bus.id_read1sel == m_wrsel) ||
              (bus.id_uses_rt && bus.id_read2sel == m_wrsel);
        return m_valid && m_memread && m_regwrite && bus.id_valid && dep;
    endfunction

    function automatic bit model_stall();
        return !bus.flush && (bus.ex_hold || model_lu());
    endfunction

    task automatic model_edge();
        if (bus.flush) begin
            model_bubble();
        end else if (bus.ex_hold) begin
            // frozen
        end else if (model_lu()) begin
            model_bubble();
            m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
        end else begin
            m_valid    = bus.id_valid;
            m_regwrite = bus.id_valid & bus.id_regwrite;
            m_memread  = bus.id_valid & bus.id_memread;
            m_err      = bus.id_valid & bus.id_err;
            m_r1       = bus.id_read1data;
            m_r2       = bus.id_read2data;
            m_imm      = bus.id_imm;
            m_pc       = bus.id_pc;
            m_wrsel    = bus.id_wrsel;
        end
    endtask

    task automatic check_outputs();
        check("ex_valid",     32'(bus.ex_valid),     32'(m_valid));
        check("ex_regwrite",  32'(bus.ex_regwrite),  32'(m_regwrite));
        check("ex_memread",   32'(bus.ex_memread),   32'(m_memread));
        check("ex_err",       32'(bus.ex_err),       32'(m_err));
        check("ex_read1data", 32'(bus.ex_read1data), 32'(m_r1));
        check("ex_read2data", 32'(bus.ex_read2data), 32'(m_r2));
        check("ex_imm",       32'(bus.ex_imm),       32'(m_imm));
        check("ex_pc",        32'(bus.ex_pc),        32'(m_pc));
        check("ex_wrsel",     32'(bus.ex_wrsel),     32'(m_wrsel));
        check("stall_cnt",    32'(bus.stall_cnt),    32'(m_cnt));
    endtask

    // One clock: check stall_id before the edge, step the model, check EX after
    task automatic cycle();
        #1;
        check("stall_id", 32'(bus.stall_id), 32'(model_stall()));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    // Drive one decode instruction; operand data, imm, pc are random
    task automatic set_instr(input logic v, input logic [RW-1:0] s1, input logic [RW-1:0] s2,
                             input logic urs, input logic urt, input logic [RW-1:0] ws,
                             input logic rw, input logic mr);
        bus.id_valid     = v;
        bus.id_read1sel  = s1;
        bus.id_read2sel  = s2;
        bus.id_uses_rs   = urs;
        bus.id_uses_rt   = urt;
        bus.id_wrsel     = ws;
        bus.id_regwrite  = rw;
        bus.id_memread   = mr;
        bus.id_read1data = DW'($urandom);
        bus.id_read2data = DW'($urandom);
        bus.id_imm       = DW'($urandom);
        bus.id_pc        = DW'($urandom);
        bus.id_err       = 1'b0;
    endtask

    // Short reset pulse between edges; outputs must clear without a clock
    task automatic reset_pulse();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs();
        rst = 1'b0;
    endtask

    int cnt_before;

    initial begin
        rst = 1'b1;
        bus.flush   = 1'b0;
        bus.ex_hold = 1'b0;
        set_instr(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1);
        model_reset();

        // Reset state, before and across a clock edge
        #2;
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;

        // Mid-cycle reset with a valid instruction in EX
        set_instr(1'b1, 3'd1, 3'd2, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0);
        bus.id_err = 1'b1;
        cycle();
        check("pre_rst_valid", 32'(bus.ex_valid), 32'd1);
        reset_pulse();
        check("rst_async_valid", 32'(bus.ex_valid), 32'd0);

        // Load r3 then add reading r3 on rs: exactly one bubble
        set_instr(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1);
        cycle();
        cnt_before = m_cnt;
        set_instr(1'b1, 3'd3, 3'd5, 1'b1, 1'b1, 3'd6, 1'b1, 1'b0);
        #1;
        check("lu_stall_id", 32'(bus.stall_id), 32'd1);
        cycle();
        check("lu_bubble", 32'(bus.ex_valid), 32'd0);
        check("lu_cnt", 32'(bus.stall_cnt), 32'(cnt_before + 1));
        cycle();
        check("lu_add_valid", 32'(bus.ex_valid), 32'd1);
        check("lu_add_wrsel", 32'(bus.ex_wrsel), 32'd6);

        // Load r3 then read2sel=3 with uses_rt=0: no stall
        set_instr(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1);
        cycle();
        cnt_before = m_cnt;
        set_instr(1'b1, 3'd5, 3'd3, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0);
        #1;
        check("no_dep_stall_id", 32'(bus.stall_id), 32'd0);
        cycle();
        check("no_dep_valid", 32'(bus.ex_valid), 32'd1);
        check("no_dep_cnt", 32'(bus.stall_cnt), 32'(cnt_before));

        // Load-use with flush in the same cycle: bubble, no count, no stall
        set_instr(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1);
        cycle();
        cnt_before = m_cnt;
        set_instr(1'b1, 3'd3, 3'd3, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0);
        bus.flush = 1'b1;
        #1;
        check("flush_stall_id", 32'(bus.stall_id), 32'd0);
        cycle();
        check("flush_bubble", 32'(bus.ex_valid), 32'd0);
        check("flush_cnt", 32'(bus.stall_cnt), 32'(cnt_before));
        bus.flush = 1'b0;

        // Register 0 is not special
        set_instr(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
        cycle();
        set_instr(1'b1, 3'd7, 3'd0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
        #1;
        check("r0_stall_id", 32'(bus.stall_id), 32'd1);
        cycle();
        cycle();

        // Hold for three cycles with 0x1234 in EX
        set_instr(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0);
        bus.id_read1data = 16'h1234;
        cycle();
        bus.ex_hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_instr(1'b1, 3'd6, 3'd7, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0);
            #1;
            check("hold_stall_id", 32'(bus.stall_id), 32'd1);
            cycle();
            check("hold_r1", 32'(bus.ex_read1data), 32'h1234);
        end
        bus.ex_hold = 1'b0;
        bus.id_read1data = 16'hBEEF;
        cycle();
        check("release_r1", 32'(bus.ex_read1data), 32'hBEEF);

        // Reset while held: held instruction discarded
        bus.ex_hold = 1'b1;
        cycle();
        reset_pulse();
        bus.ex_hold = 1'b0;
        cycle();

        // Randomized traffic with dense register reuse
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 99) == 0) reset_pulse();
            set_instr(1'($urandom_range(0, 7) != 0),
                      RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
                      1'($urandom), 1'($urandom), RW'($urandom_range(0, 3)),
                      1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) < 2));
            bus.id_err  = 1'($urandom_range(0, 7) == 0);
            bus.flush   = 1'($urandom_range(0, 9) == 0);
            bus.ex_hold = 1'($urandom_range(0, 6) == 0);
            cycle();
        end
        bus.flush   = 1'b0;
        bus.ex_hold = 1'b0;

        // 260 load-use pairs: counter saturates at 255 and stays there
        for (int p = 0; p < 260; p++) begin
            set_instr(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1);
            cycle();
            set_instr(1'b1, 3'd2, 3'd4, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0);
            cycle();
            cycle();
        end
        check("sat_cnt", 32'(bus.stall_cnt), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DW, 16, datapath width of register operands, immediate and PC.
REQ-002 Parameter RW, 3, register-select width (8 registers).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 id_valid  input  1  decode stage holds a real instruction.
REQ-006 id_read1data / id_read2data  input  DW each  operands from bypassing register file.
REQ-007 id_read1sel / id_read2sel  input  RW each  source registers of decode instruction.
REQ-008 id_uses_rs / id_uses_rt  input  1 each  instruction actually consumes read1 / read2 operand.
REQ-009 id_wrsel  input  RW  destination register; id_regwrite input 1 writes a register; id_memread input 1 is a load.
REQ-010 id_imm / id_pc  input  DW each  immediate and PC+2 of decode instruction.
REQ-011 id_err  input  1  register-file error for this instruction.
REQ-012 flush  input  1  branch/jump redirect; kill decode instruction.
REQ-013 ex_hold  input  1  downstream cannot accept; freeze EX register.
REQ-014 ex_valid, ex_regwrite, ex_memread, ex_err  output  1 each  registered EX-stage control.
REQ-015 ex_read1data, ex_read2data, ex_imm, ex_pc  output  DW each; ex_wrsel output RW  registered EX-stage data.
REQ-016 stall_id  output  1  combinational; tells IF/ID to hold current instruction.
REQ-017 stall_cnt  output  8  registered count of load-use bubbles inserted.

Function
REQ-018 Load-use hazard (lu) SHALL be: ex_valid & ex_memread & ex_regwrite & id_valid & ((id_uses_rs & id_read1sel==ex_wrsel) | (id_uses_rt & id_read2sel==ex_wrsel)).
REQ-019 stall_id SHALL equal ~flush & (ex_hold | lu); combinational, no registered delay.
REQ-020 Per-edge update priority SHALL be: rst > flush > ex_hold > lu > normal.
REQ-021 flush: EX register SHALL load a bubble regardless of ex_hold or lu.
REQ-022 ex_hold (no flush): every EX output register SHALL keep its value; stall_cnt unchanged.
REQ-023 lu (no flush, no ex_hold): EX register SHALL load a bubble and stall_cnt SHALL increment by 1, saturating at 255.
REQ-024 Normal: EX register SHALL capture all id_* fields; ex_valid=id_valid; ex_regwrite/ex_memread/ex_err forced 0 when id_valid=0.
REQ-025 Bubble SHALL be: ex_valid, ex_regwrite, ex_memread, ex_err = 0; all DW/RW data fields = 0.
REQ-026 Latency: a non-stalled decode instruction SHALL appear on ex_* exactly 1 cycle later.
REQ-027 A load-use pair SHALL incur exactly one bubble: after the bubble ex_memread=0, so lu deasserts and the held instruction captures on the next edge.
REQ-028 Register 0 SHALL NOT be special: ex_wrsel==0 matching a source still raises lu.
REQ-029 Register-select comparison SHALL be full RW-bit equality; no wrap or masking.

Reset
REQ-030 While rst=1, all EX outputs SHALL be 0 and stall_cnt SHALL be 0, immediately and without waiting for clk.
REQ-031 Reset asserted mid-stall or mid-hold SHALL discard the held instruction; first edge after rst deasserts behaves per REQ-020 on current inputs.
REQ-032 stall_cnt SHALL clear only on rst.

Verification
REQ-033 rst pulse mid-cycle with ex_valid=1 -> all outputs 0 before next clk edge; stall_cnt=0.
REQ-034 Load r3 (memread=1, regwrite=1, wrsel=3) followed by add using read1sel=3, uses_rs=1 -> stall_id=1 one cycle, one bubble (ex_valid=0), add reaches EX next cycle, stall_cnt=1.
REQ-035 Same load followed by instruction with read2sel=3 but uses_rt=0 -> no stall, back-to-back capture, stall_cnt unchanged.
REQ-036 Load-use hazard with flush=1 same cycle -> stall_id=0, bubble loaded, stall_cnt unchanged.
REQ-037 ex_hold=1 for 3 cycles with ex_read1data=0x1234 -> outputs frozen at 0x1234, stall_id=1 throughout; on release next id fields captured.
REQ-038 256 consecutive load-use pairs -> stall_cnt saturates at 255 and holds.
